io_timer: RTL and testbench

- Memory-mapped 16-bit timer/counter that acts as a responder on the CPU data-memory/I/O bus.
- Uses the same bus signals the core drives: 16-bit address, 8-bit write data, write enable, read enable, and an 8-bit read data return registered on clk.
- Decodes a small register window, counts prescaled clock ticks and compares against a programmable value.
- Raises a level interrupt request toward the core's interrupt logic (vector 0x00FF).

---
 rtl/io_pkg.sv | 33 +++
 rtl/io_prescaler.sv | 34 +++
 rtl/io_timer.sv | 186 ++++++++++++++++++
 tb/tb_io_timer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared I/O responder definitions: register offsets, CTRL/STATUS bit indices, default base.
// The capture feature is compiled in with TIMER_CAPTURE_EN.
package io_pkg;

  localparam logic [15:0] IO_TMR_BASE_DEFAULT = 16'h0010;

  localparam logic [3:0] IO_TMR_CTRL   = 4'h0;
  localparam logic [3:0] IO_TMR_PRESC  = 4'h1;
  localparam logic [3:0] IO_TMR_CNT_LO = 4'h2;
  localparam logic [3:0] IO_TMR_CNT_HI = 4'h3;
  localparam logic [3:0] IO_TMR_CMP_LO = 4'h4;
  localparam logic [3:0] IO_TMR_CMP_HI = 4'h5;
  localparam logic [3:0] IO_TMR_STATUS = 4'h6;
  localparam logic [3:0] IO_TMR_SHADOW = 4'h7;
  localparam logic [3:0] IO_TMR_CAP_LO = 4'h8;
  localparam logic [3:0] IO_TMR_CAP_HI = 4'h9;

  localparam int CTRL_EN           = 0;
  localparam int CTRL_CLR_ON_MATCH = 1;
  localparam int CTRL_IE_MATCH     = 2;
  localparam int CTRL_IE_OVF       = 3;
  localparam int CTRL_IE_CAP       = 4;

  localparam int STAT_MATCH = 0;
  localparam int STAT_OVF   = 1;
  localparam int STAT_CAP   = 2;

  // A responder owns a 16-byte window; only the upper 12 address bits decode.
  function automatic logic ioWindowHit(input logic [15:0] addr, input logic [15:0] base);
    return addr[15:4] == base[15:4];
  endfunction

endpackage

// File: rtl/io_prescaler.sv
// Reusable 8-bit clock prescaler: one-cycle tick every presc+1 clocks while en is high.
module io_prescaler (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] presc,
  output logic       tick
);

  logic [7:0] countReg;
  logic [7:0] countNext;

  // Tick is raised in the cycle whose update lands the counter on 0, so the
  // first tick after enabling arrives presc+1 clocks after en goes high.
  always_comb begin
    countNext = countReg;
    tick      = 1'b0;
    if (!en) begin
      countNext = 8'd0;
    end else if (countReg == 8'd0) begin
      countNext = presc;
      tick      = (presc == 8'd0);
    end else begin
      countNext = countReg - 8'd1;
      tick      = (countReg == 8'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) countReg <= 8'd0;
    else     countReg <= countNext;
  end

endmodule

// File: rtl/io_timer.sv
// Memory-mapped 16-bit timer/counter responder with compare match, overflow and level irq.
// Define TIMER_CAPTURE_EN to add the cap_in input-capture registers.
module io_timer
  import io_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = IO_TMR_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [7:0]  din,
  input  logic        w_en,
  input  logic        r_en,
  output logic [7:0]  dout,
  output logic        sel_q,
  input  logic        cap_in,
  output logic        irq
);

`ifdef TIMER_CAPTURE_EN
  localparam int CTRL_W = 5;
`else
  localparam int CTRL_W = 4;
`endif

  logic [CTRL_W-1:0] ctrlReg, ctrlNext;
  logic [7:0]        prescReg, prescNext;
  logic [15:0]       cntReg, cntNext;
  logic [15:0]       cmpReg, cmpNext;
  logic              matchReg, matchNext;
  logic              ovfReg, ovfNext;
  logic [7:0]        shadowReg, shadowNext;
  logic [7:0]        doutReg;
  logic              selReg;
  logic              irqReg;
  logic              capFlag;
  logic [15:0]       capValue;
  logic              capIrq;

  logic        hit, wrHit, rdHit;
  logic [3:0]  offset;
  logic        tick;
  logic [15:0] cntInc;
  logic        matchHit, ovfHit;
  logic        matchSet, ovfSet;
  logic        clrStatus0, clrStatus1;
  logic [7:0]  rdData;

  assign hit    = ioWindowHit(addr, BASE_ADDR);
  assign offset = addr[3:0];
  assign wrHit  = w_en & hit;
  assign rdHit  = r_en & hit;

  io_prescaler u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .en    (ctrlReg[CTRL_EN]),
    .presc (prescReg),
    .tick  (tick)
  );

  assign cntInc   = cntReg + 16'd1;
  assign matchHit = (cntInc == cmpReg);
  // Clear-on-match with CMP=FFFF folds the wrap into the match reload, so flag OVF too.
  assign ovfHit   = (cntReg == 16'hFFFF) |
                    (matchHit & ctrlReg[CTRL_CLR_ON_MATCH] & (cmpReg == 16'hFFFF));

  assign clrStatus0 = wrHit & (offset == IO_TMR_STATUS) & din[STAT_MATCH];
  assign clrStatus1 = wrHit & (offset == IO_TMR_STATUS) & din[STAT_OVF];

  always_comb begin
    ctrlNext   = ctrlReg;
    prescNext  = prescReg;
    cmpNext    = cmpReg;
    cntNext    = cntReg;
    shadowNext = shadowReg;
    matchSet   = 1'b0;
    ovfSet     = 1'b0;

    if (wrHit) begin
      case (offset)
        IO_TMR_CTRL:   ctrlNext       = din[CTRL_W-1:0];
        IO_TMR_PRESC:  prescNext      = din;
        IO_TMR_CMP_LO: cmpNext[7:0]   = din;
        IO_TMR_CMP_HI: cmpNext[15:8]  = din;
        default:       ;
      endcase
    end

    // A bus write to either count byte replaces this cycle's tick entirely.
    if (wrHit && offset == IO_TMR_CNT_LO) begin
      cntNext[7:0] = din;
    end else if (wrHit && offset == IO_TMR_CNT_HI) begin
      cntNext[15:8] = din;
    end else if (tick) begin
      matchSet = matchHit;
      ovfSet   = ovfHit;
      cntNext  = (matchHit && ctrlReg[CTRL_CLR_ON_MATCH]) ? 16'd0 : cntInc;
    end

    if (rdHit && offset == IO_TMR_CNT_LO) shadowNext = cntReg[15:8];

    matchNext = (matchReg & ~clrStatus0) | matchSet;
    ovfNext   = (ovfReg & ~clrStatus1) | ovfSet;
  end

`ifdef TIMER_CAPTURE_EN
  logic [2:0]  capSyncReg;
  logic        capEdge;
  logic        capFlagReg;
  logic [15:0] capReg;

  assign capEdge = capSyncReg[1] & ~capSyncReg[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      capSyncReg <= 3'b000;
      capFlagReg <= 1'b0;
      capReg     <= 16'd0;
    end else begin
      capSyncReg <= {capSyncReg[1:0], cap_in};
      capFlagReg <= (capFlagReg & ~(wrHit & (offset == IO_TMR_STATUS) & din[STAT_CAP])) | capEdge;
      if (capEdge) capReg <= cntReg;
    end
  end

  assign capFlag  = capFlagReg;
  assign capValue = capReg;
  assign capIrq   = ctrlReg[CTRL_IE_CAP] & capFlagReg;
`else
  logic unusedCapIn;
  assign unusedCapIn = cap_in;
  assign capFlag     = 1'b0;
  assign capValue    = 16'd0;
  assign capIrq      = 1'b0;
`endif

  always_comb begin
    rdData = 8'h00;
    case (offset)
      IO_TMR_CTRL:   rdData = 8'(ctrlReg);
      IO_TMR_PRESC:  rdData = prescReg;
      IO_TMR_CNT_LO: rdData = cntReg[7:0];
      IO_TMR_CNT_HI: rdData = cntReg[15:8];
      IO_TMR_CMP_LO: rdData = cmpReg[7:0];
      IO_TMR_CMP_HI: rdData = cmpReg[15:8];
      IO_TMR_STATUS: rdData = {5'b00000, capFlag, ovfReg, matchReg};
      IO_TMR_SHADOW: rdData = shadowReg;
      IO_TMR_CAP_LO: rdData = capValue[7:0];
      IO_TMR_CAP_HI: rdData = capValue[15:8];
      default:       rdData = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrlReg   <= '0;
      prescReg  <= 8'd0;
      cntReg    <= 16'd0;
      cmpReg    <= 16'hFFFF;
      matchReg  <= 1'b0;
      ovfReg    <= 1'b0;
      shadowReg <= 8'd0;
      doutReg   <= 8'd0;
      selReg    <= 1'b0;
      irqReg    <= 1'b0;
    end else begin
      ctrlReg   <= ctrlNext;
      prescReg  <= prescNext;
      cntReg    <= cntNext;
      cmpReg    <= cmpNext;
      matchReg  <= matchNext;
      ovfReg    <= ovfNext;
      shadowReg <= shadowNext;
      doutReg   <= rdHit ? rdData : 8'h00;
      selReg    <= rdHit;
      irqReg    <= (ctrlReg[CTRL_IE_MATCH] & matchReg) |
                   (ctrlReg[CTRL_IE_OVF] & ovfReg) | capIrq;
    end
  end

  assign dout  = doutReg;
  assign sel_q = selReg;
  assign irq   = irqReg;

endmodule

// File: tb/tb_io_timer.sv
// Directed bench for io_timer: register reads, prescaled match, overflow, shadow, W1C races, reset.
module tb_io_timer;

  localparam logic [15:0] BASE = 16'h0010;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [7:0]  din;
  logic        w_en;
  logic        r_en;
  logic        cap_in;
  logic [7:0]  dout;
  logic        sel_q;
  logic        irq;

  int checks = 0;
  int errors = 0;

  io_timer #(.BASE_ADDR(BASE)) dut (
    .clk    (clk),
    .rst    (rst),
    .addr   (addr),
    .din    (din),
    .w_en   (w_en),
    .r_en   (r_en),
    .dout   (dout),
    .sel_q  (sel_q),
    .cap_in (cap_in),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Every bus op starts on a negedge and occupies exactly one rising edge.
  task automatic wr(input logic [3:0] off, input logic [7:0] d);
    addr = BASE + 16'(off);
    din  = d;
    w_en = 1'b1;
    @(negedge clk);
    w_en = 1'b0;
  endtask

  task automatic rdA(input logic [15:0] a, output logic [7:0] d, output logic s);
    addr = a;
    r_en = 1'b1;
    @(negedge clk);
    r_en = 1'b0;
    d = dout;
    s = sel_q;
  endtask

  task automatic rdCheck(input string tag, input logic [3:0] off, input logic [7:0] exp);
    logic [7:0] d;
    logic       s;
    rdA(BASE + 16'(off), d, s);
    check(tag, d, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [7:0] d;
    logic       s;

    rst = 1'b1; addr = 16'h0; din = 8'h0; w_en = 1'b0; r_en = 1'b0; cap_in = 1'b0;
    step(2);
    check("rst_dout", dout, 8'h00);
    check("rst_sel", sel_q, 1'b0);
    check("rst_irq", irq, 1'b0);
    rst = 1'b0;

    // Reset values of every offset, one-cycle read latency
    for (int i = 0; i < 10; i++) begin
      rdA(BASE + 16'(i), d, s);
      check($sformatf("reset_rd_off%0d", i), d, (i == 4 || i == 5) ? 8'hFF : 8'h00);
      check($sformatf("reset_sel_off%0d", i), s, 1'b1);
    end
    step(1);
    check("sel_idle", sel_q, 1'b0);
    rdA(BASE + 16'd16, d, s);
    check("oow_dout", d, 8'h00);
    check("oow_sel", s, 1'b0);

    // Prescaled compare with clear-on-match: PRESC=3, CMP=5, CTRL=0111
    wr(4'h1, 8'd3);
    wr(4'h4, 8'd5);
    wr(4'h5, 8'd0);
    wr(4'h0, 8'h07);
    rdCheck("ctrl_readback", 4'h0, 8'h07);
    step(2);
    rdCheck("cnt_before_first_tick", 4'h2, 8'h00);
    rdCheck("cnt_first_tick", 4'h2, 8'h01);
    step(14);
    check("irq_before_match", irq, 1'b0);
    rdCheck("cnt_before_match", 4'h2, 8'h04);
    check("irq_match_delay", irq, 1'b0);
    rdCheck("status_match", 4'h6, 8'h01);
    check("irq_after_match", irq, 1'b1);
    rdCheck("cnt_cleared", 4'h2, 8'h00);
    wr(4'h6, 8'h01);
    check("irq_clear_delay", irq, 1'b1);
    step(1);
    check("irq_dropped", irq, 1'b0);
    rdCheck("status_cleared", 4'h6, 8'h00);

    // Overflow: CNT=FFFE, PRESC=0, CTRL=1001
    wr(4'h0, 8'h00);
    wr(4'h6, 8'h03);
    wr(4'h1, 8'h00);
    wr(4'h2, 8'hFE);
    wr(4'h3, 8'hFF);
    wr(4'h0, 8'h09);
    rdCheck("ovf_status_pre", 4'h6, 8'h00);
    rdCheck("ovf_cnt_hi_ffff", 4'h3, 8'hFF);
    check("ovf_irq_delay", irq, 1'b0);
    rdCheck("ovf_status_set", 4'h6, 8'h02);
    check("ovf_irq", irq, 1'b1);
    rdCheck("ovf_cnt_wrapped", 4'h2, 8'h01);

    // Shadowed 16-bit read across a carry
    wr(4'h2, 8'hFF);
    wr(4'h3, 8'h12);
    rdCheck("shadow_lo", 4'h2, 8'hFF);
    rdCheck("shadow_hi", 4'h7, 8'h12);
    rdCheck("live_hi", 4'h3, 8'h13);

    // Set-wins race on MATCH, then count write overriding a tick
    wr(4'h6, 8'h03);
    wr(4'h4, 8'h20);
    wr(4'h3, 8'h00);
    wr(4'h2, 8'h1E);
    step(1);
    wr(4'h6, 8'h01);
    rdCheck("match_set_wins", 4'h6, 8'h01);
    wr(4'h2, 8'h40);
    rdCheck("cnt_write_no_inc", 4'h2, 8'h40);
    rdCheck("cnt_write_hi_kept", 4'h3, 8'h00);

    // Input capture
    wr(4'h6, 8'h07);
    wr(4'h0, 8'h1F);
`ifdef TIMER_CAPTURE_EN
    rdCheck("ctrl_ie_cap", 4'h0, 8'h1F);
    wr(4'h0, 8'h01);
    wr(4'h2, 8'h00);
    wr(4'h3, 8'h01);
    cap_in = 1'b1;
    step(3);
    rdCheck("cap_lo", 4'h8, 8'h02);
    rdCheck("cap_hi", 4'h9, 8'h01);
    rdCheck("cap_status", 4'h6, 8'h04);
`else
    rdCheck("ctrl_no_ie_cap", 4'h0, 8'h0F);
    wr(4'h0, 8'h01);
    wr(4'h6, 8'h07);
    cap_in = 1'b1;
    step(4);
    rdCheck("cap_lo_absent", 4'h8, 8'h00);
    rdCheck("cap_hi_absent", 4'h9, 8'h00);
    rdCheck("cap_status_absent", 4'h6, 8'h00);
`endif
    cap_in = 1'b0;

    // Reset with a read in flight
    wr(4'h0, 8'h09);
    addr = BASE + 16'h4;
    r_en = 1'b1;
    rst  = 1'b1;
    @(negedge clk);
    r_en = 1'b0;
    rst  = 1'b0;
    check("midrst_dout", dout, 8'h00);
    check("midrst_sel", sel_q, 1'b0);
    check("midrst_irq", irq, 1'b0);
    rdCheck("midrst_cmp_lo", 4'h4, 8'hFF);
    rdCheck("midrst_cnt_lo", 4'h2, 8'h00);
    rdCheck("midrst_ctrl", 4'h0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
